// File: rtl/dmem_stall_responder.sv
// Multi-cycle data-memory responder: word-organised 16-bit memory with a fixed
// request-to-done latency. Optional last-access fast path under DMEM_FAST_HIT_EN.
module dmem_stall_responder #(
    parameter int ADDR_W  = 13,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        busy,
    output logic        err,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic [15:0]       mem [2**ADDR_W];
    logic [15:0]       rd_buf;
    logic              pend_rd;
    logic [ADDR_W-1:0] idx;
    logic              open_slot;
    logic              accept;
    logic              misalign;
    logic              short_path;
    logic              unused_addr_hi;

    // Handshake: enable is a one-cycle request, taken at the edge whenever
    // busy is low; while busy is high it is dropped with no side effects.
    assign idx            = addr[ADDR_W:1];
    assign unused_addr_hi = ^addr[15:ADDR_W+1];
    assign open_slot      = (state != WAIT);
    assign accept         = !rst && enable && !addr[0] && open_slot;
    assign misalign       = !rst && enable &&  addr[0] && open_slot;

`ifdef DMEM_FAST_HIT_EN
    logic              hit_valid;
    logic [ADDR_W-1:0] hit_tag;

    // Reads repeating the last accessed word index skip the wait entirely.
    assign short_path = (LATENCY == 2) || (hit_valid && (hit_tag == idx) && !wr);

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_valid <= 1'b0;
            hit_tag   <= '0;
        end else if (accept) begin
            hit_valid <= 1'b1;
            hit_tag   <= idx;
        end
    end
`else
    assign short_path = (LATENCY == 2);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, RESP: begin
                if (accept) state_next = short_path ? RESP : WAIT;
                else        state_next = IDLE;
            end
            WAIT:    if (cnt == 4'd0) state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        done      = (state == RESP);
        stall     = (state == WAIT);
        busy      = (state == WAIT);
        fsm_state = state;
    end

    always_ff @(posedge clk) begin
        if (rst)                            cnt <= 4'd0;
        else if (accept)                    cnt <= 4'(LATENCY - 2);
        else if (state == WAIT && cnt != 0) cnt <= cnt - 4'd1;
    end

    // Memory is not reset; writes commit at the acceptance edge.
    always_ff @(posedge clk) begin
        if (accept && wr) mem[idx] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            data_out <= 16'h0000;
            rd_buf   <= 16'h0000;
            pend_rd  <= 1'b0;
        end else begin
            err <= misalign;
            if (accept) begin
                pend_rd <= !wr;
                rd_buf  <= mem[idx];
                if (!wr && short_path) data_out <= mem[idx];
            end else if (state == WAIT && cnt == 4'd0 && pend_rd) begin
                data_out <= rd_buf;
            end
        end
    end

endmodule
